// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared single-port data memory.
// Registered grants, bounded locked bursts, registered per-port read data.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Lock0,
  input  logic              Lock1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic              RValid0,
  output logic              RValid1,
  output logic              MemWriteEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemDataIn,
  input  logic [DATA_W-1:0] MemDataOut
);

  typedef enum logic [1:0] {
    IDLE,
    G0,
    G1
  } state_t;

  localparam logic [3:0] CAP = 4'(MAX_BURST - 1);

  state_t     state;
  state_t     nxt;
  logic       rrptr;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       beat0;
  logic       beat1;

  assign beat0 = (state == G0) & Req0;
  assign beat1 = (state == G1) & Req1;

  function automatic state_t pick(
    input logic r0,
    input logic r1,
    input logic p
  );
    state_t s;
    s = IDLE;
    unique case (1'b1)
      (r0 & r1): s = p ? G1 : G0;
      (r0 & ~r1): s = G0;
      (~r0 & r1): s = G1;
      default: s = IDLE;
    endcase
    return s;
  endfunction

  // cnt_nxt defaults to 0 so any exit or unlocked beat clears the burst
  always_comb begin
    nxt     = state;
    cnt_nxt = '0;
    unique case (state)
      IDLE: nxt = pick(Req0, Req1, rrptr);
      G0: begin
        if (!Req0) begin
          nxt = pick(1'b0, Req1, rrptr);
        end else if (Lock0 && (cnt < CAP || !Req1)) begin
          nxt     = G0;
          cnt_nxt = (cnt < CAP) ? cnt + 4'd1 : 4'd0;
        end else if (Req1) begin
          nxt = G1;
        end else begin
          nxt = G0;
        end
      end
      G1: begin
        if (!Req1) begin
          nxt = pick(Req0, 1'b0, rrptr);
        end else if (Lock1 && (cnt < CAP || !Req0)) begin
          nxt     = G1;
          cnt_nxt = (cnt < CAP) ? cnt + 4'd1 : 4'd0;
        end else if (Req0) begin
          nxt = G0;
        end else begin
          nxt = G1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    MemAddr    = '0;
    MemDataIn  = '0;
    MemWriteEn = 1'b0;
    unique case (state)
      G0: begin
        MemAddr    = Addr0;
        MemDataIn  = WData0;
        MemWriteEn = Req0 & We0 & ~Reset;
      end
      G1: begin
        MemAddr    = Addr1;
        MemDataIn  = WData1;
        MemWriteEn = Req1 & We1 & ~Reset;
      end
      default: begin
        MemAddr    = '0;
        MemDataIn  = '0;
        MemWriteEn = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      Gnt0    <= 1'b0;
      Gnt1    <= 1'b0;
      rrptr   <= 1'b0;
      cnt     <= '0;
      RData0  <= '0;
      RData1  <= '0;
      RValid0 <= 1'b0;
      RValid1 <= 1'b0;
    end else begin
      state   <= nxt;
      Gnt0    <= (nxt == G0);
      Gnt1    <= (nxt == G1);
      cnt     <= cnt_nxt;
      // leaving a grant hands priority to the other port
      if (state != IDLE && nxt != state)
        rrptr <= (state == G0);
      RValid0 <= beat0 & ~We0;
      RValid1 <= beat1 & ~We1;
      if (beat0 & ~We0)
        RData0 <= MemDataOut;
      if (beat1 & ~We1)
        RData1 <= MemDataOut;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x8 data memory between two requesters: port 0 (processor core load/store path) and port 1 (auxiliary loader/dump engine).
- Implements a registered req/gnt handshake with round-robin fairness and bounded locked bursts.
- Drives the memory's write enable, address and write data, and returns registered read data per port.
- Sits between the requesters and the data memory. The memory read is combinational; the memory write is clocked.

Parameters:
- ADDR_W, 8, address width; memory depth is 2^ADDR_W.
- DATA_W, 8, data width.
- MAX_BURST, 4, maximum consecutive locked beats while the other port is waiting; legal range 1..15.

Ports:
- Clk  in  1  clock.
- Reset  in  1  reset, synchronous, active-high.
- Req0/Req1  in  1  access request; held until the beat completes.
- Lock0/Lock1  in  1  request to retain the grant for the following beat (burst).
- We0/We1  in  1  1 = write, 0 = read.
- Addr0/Addr1  in  ADDR_W  access address.
- WData0/WData1  in  DATA_W  write data.
- Gnt0/Gnt1  out  1  registered grant; a beat occurs in any cycle where Gntx=1 and Reqx=1.
- RData0/RData1  out  DATA_W  captured read data.
- RValid0/RValid1  out  1  one-cycle pulse, one cycle after a read beat.
- MemWriteEn  out  1  memory write enable.
- MemAddr  out  ADDR_W  memory address.
- MemDataIn  out  DATA_W  memory write data.
- MemDataOut  in  DATA_W  memory combinational read data.

Behaviour:
- Reset values:
  - state IDLE; Gnt0=Gnt1=0; RRPtr=0 (port 0 favoured); BeatCnt=0.
  - RData0=RData1=0; RValid0=RValid1=0.
  - MemWriteEn=0 in every cycle Reset=1, overriding all other conditions.
- States:
  - IDLE: no grant.
  - G0: Gnt0=1.
  - G1: Gnt1=1.
  - Gnt0 and Gnt1 are never both 1.
- Memory mux (combinational from state):
  - In Gx: MemAddr=Addrx, MemDataIn=WDatax, MemWriteEn=Reqx&Wex.
  - In IDLE: MemAddr=0, MemDataIn=0, MemWriteEn=0.
- Latency:
  - Req sampled in IDLE at edge N gives Gnt at cycle N+1; the beat executes in that cycle.
  - A write commits at the end of the beat cycle.
  - A read: RDatax <= MemDataOut at the end of the beat cycle; RValidx=1 for the following cycle only.
  - RDatax holds its value until the next read beat on that port.
- Next-state decision, evaluated every cycle from the current inputs:
  - IDLE:
    - Both requesting: grant the port selected by RRPtr.
    - One requesting: grant it.
    - None: stay in IDLE.
  - Gx, with Reqx=0 (requester withdrew): no beat. Choose the next state as in IDLE, ignoring port x.
  - Gx, with Reqx=1 and Lockx=1, and (BeatCnt<MAX_BURST-1 or Req_other=0): stay in Gx.
    - BeatCnt increments, saturating at MAX_BURST-1.
    - BeatCnt resets to 0 if the other port is idle at the cap.
  - Gx, otherwise:
    - Req_other=1: go to G_other.
    - Req_other=0 and Reqx=1: stay in Gx. This is back-to-back single beats with no bubble.
    - Neither requesting: go to IDLE.
- Grant-end bookkeeping: on any transition out of Gx, RRPtr <= other port and BeatCnt <= 0.
- Starvation bound: a waiting port is granted within MAX_BURST+1 cycles of asserting Req.
- Simultaneous events: a read beat on one port and a new request on the other in the same cycle are legal. The grant handoff happens on the next edge with no idle cycle.
- Reset mid-burst: the burst is aborted, no write occurs in the reset cycle, and the next cycle is IDLE with all outputs at reset values.
- Address wraps naturally at ADDR_W bits; there is no range checking.

Test Plan:
- Port 0 single write, Addr0=0x40, WData0=0xA5, then a read of 0x40 -> Gnt0 one cycle after Req0, MemWriteEn=1 for exactly one cycle, RValid0 pulse, RData0=0xA5.
- Both ports request in the same cycle from reset -> G0 first (RRPtr=0), G1 next cycle. Repeat both requests -> G0 then G1 again (alternation). Gnt0 and Gnt1 are never both high.
- Port 1 locked burst of 8 reads (0x00..0x07) while port 0 requests continuously, MAX_BURST=4 -> G1 for 4 beats, then G0 for 1 beat, then G1 resumes. RData1 sequence matches preloaded bytes 0x52,0x03,0xE6,0x05,...
- Port 1 locked burst of 6 with port 0 idle -> 6 consecutive G1 beats with no forced release.
- Req0 dropped while Gnt0=1, We0=1 -> MemWriteEn=0 that cycle, memory unchanged, state goes to IDLE (or G1 if Req1=1).
- Reset asserted in the 2nd beat of a locked port 0 write burst -> MemWriteEn=0 in the reset cycle, Gnt0=0 next cycle, and the addressed memory byte shows no write from that beat.
